// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 set-2 scan decoder: prefix bytes, key event layout,
// decoder state encoding.
package kbd_pkg;

   localparam logic [7:0] SC_EXT  = 8'hE0;
   localparam logic [7:0] SC_BRK  = 8'hF0;
   localparam logic [7:0] SC_E1   = 8'hE1;
   localparam logic [7:0] SC_ERR0 = 8'h00;
   localparam logic [7:0] SC_ERR1 = 8'hFF;

   localparam int unsigned KEY_W   = 10;
   localparam int unsigned BRK_BIT = 9;
   localparam int unsigned EXT_BIT = 8;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StExt    = 2'd1;
   localparam logic [1:0] StBrk    = 2'd2;
   localparam logic [1:0] StExtBrk = 2'd3;

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit to tell full from empty.
module kbd_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned W     = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         accepted,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic         full
);

   logic [AW:0]  wp_q, rp_q;
   logic [W-1:0] mem [DEPTH];
   logic         do_pop;

   assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign valid    = (wp_q != rp_q);
   assign do_pop   = pop && valid;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign accepted = push && (!full || do_pop);
   assign dout     = valid ? mem[rp_q[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (accepted) wp_q <= wp_q + {{AW{1'b0}}, 1'b1};
         if (do_pop)   rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (accepted) mem[wp_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/kbd_scan_decoder.sv
// Brings keyboard scan bytes into the CPU clock domain, folds E0/F0 prefixes into
// 10-bit key events and queues them for the CPU.
module kbd_scan_decoder
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [7:0]       KCODE,
   input  logic             KCOME,
   input  logic             RD,
   input  logic             CLR_OVF,
   output logic [KEY_W-1:0] KEY,
   output logic             VALID,
   output logic             FULL,
   output logic             OVF
);

   logic             s1_q, s2_q, s3_q;
   logic             hit;
   logic [1:0]       state_q, state_d;
   logic             push, accepted, is_err;
   logic             ev_brk, ev_ext;
   logic [KEY_W-1:0] ev;
   logic             ovf_q;

   // Reset to 1 so a strobe already high at reset release yields no rising edge.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= KCOME;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign hit    = s2_q && !s3_q;
   assign is_err = (KCODE == SC_ERR0) || (KCODE == SC_ERR1) || (KCODE == SC_E1);

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      ev_brk  = 1'b0;
      ev_ext  = 1'b0;
      if (hit) begin
         case (state_q)
            StIdle: begin
               if (KCODE == SC_EXT)      state_d = StExt;
               else if (KCODE == SC_BRK) state_d = StBrk;
               else if (!is_err)         push = 1'b1;
            end
            StExt: begin
               if (KCODE == SC_BRK)      state_d = StExtBrk;
               else if (KCODE == SC_EXT) state_d = StExt;
               else begin
                  state_d = StIdle;
                  push    = !is_err;
                  ev_ext  = 1'b1;
               end
            end
            StBrk: begin
               if (KCODE == SC_BRK) state_d = StBrk;
               else begin
                  state_d = StIdle;
                  push    = !is_err && (KCODE != SC_EXT);
                  ev_brk  = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               push    = !is_err && (KCODE != SC_EXT) && (KCODE != SC_BRK);
               ev_brk  = 1'b1;
               ev_ext  = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      ev          = '0;
      ev[7:0]     = KCODE;
      ev[BRK_BIT] = ev_brk;
      ev[EXT_BIT] = ev_ext;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= StIdle;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // A fresh drop outranks a simultaneous clear.
         if (push && !accepted) ovf_q <= 1'b1;
         else if (CLR_OVF)      ovf_q <= 1'b0;
      end
   end

   kbd_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (KEY_W)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RSTN),
      .push     (push),
      .din      (ev),
      .pop      (RD),
      .accepted (accepted),
      .dout     (KEY),
      .valid    (VALID),
      .full     (FULL)
   );

   assign OVF = ovf_q;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed and randomized checks of kbd_scan_decoder against a queue-based event model.
module tb_kbd_scan_decoder;

   localparam int unsigned DEPTH = 16;

   logic       CLK = 1'b0;
   logic       RSTN = 1'b0;
   logic [7:0] KCODE = 8'h00;
   logic       KCOME = 1'b0;
   logic       RD = 1'b0;
   logic       CLR_OVF = 1'b0;
   logic [9:0] KEY;
   logic       VALID, FULL, OVF;

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] mq[$];
   bit         m_ext, m_brk, m_ovf;

   kbd_scan_decoder #(
      .DEPTH (DEPTH),
      .AW    (4)
   ) dut (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .KCODE   (KCODE),
      .KCOME   (KCOME),
      .RD      (RD),
      .CLR_OVF (CLR_OVF),
      .KEY     (KEY),
      .VALID   (VALID),
      .FULL    (FULL),
      .OVF     (OVF)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [9:0] ek;
      ek = (mq.size() != 0) ? mq[0] : 10'h000;
      chk({tag, ".valid"}, 32'(VALID), 32'(mq.size() != 0));
      chk({tag, ".key"},   32'(KEY),   32'(ek));
      chk({tag, ".full"},  32'(FULL),  32'(mq.size() == DEPTH));
      chk({tag, ".ovf"},   32'(OVF),   32'(m_ovf));
   endtask

   // Prefix bytes set pending flags; any code byte is emitted with them and clears them.
   task automatic model_byte(input logic [7:0] b, input bit popped);
      bit err;
      bit emit;
      err  = (b == 8'h00) || (b == 8'hFF) || (b == 8'hE1);
      emit = 1'b0;
      if (err) begin
         m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
         if (m_brk) begin m_ext = 0; m_brk = 0; end
         else m_ext = 1;
      end else if (b == 8'hF0) begin
         if (m_brk && m_ext) begin m_ext = 0; m_brk = 0; end
         else m_brk = 1;
      end else begin
         emit = 1'b1;
      end
      if (popped && mq.size() != 0) void'(mq.pop_front());
      if (emit) begin
         if (mq.size() < DEPTH) mq.push_back({m_brk, m_ext, b});
         else m_ovf = 1;
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      KCODE = b;
      KCOME = 1'b1;
      repeat (5) @(negedge CLK);
      KCOME = 1'b0;
      repeat (3) @(negedge CLK);
      model_byte(b, 1'b0);
   endtask

   task automatic do_read();
      @(negedge CLK);
      RD = 1'b1;
      @(negedge CLK);
      RD = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTN = 1'b0;
      #2;
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0;
      check_all("in_reset");
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      m_ext = 0; m_brk = 0; m_ovf = 0;
      #12;
      check_all("reset");
      @(negedge CLK);
      RSTN = 1'b1;
      @(negedge CLK);
      check_all("post_reset");

      // Latency of a single make code
      KCODE = 8'h1C;
      KCOME = 1'b1;
      @(posedge CLK); @(negedge CLK);
      chk("lat_n", 32'(VALID), 32'd0);
      @(posedge CLK); @(negedge CLK);
      chk("lat_n1", 32'(VALID), 32'd0);
      @(posedge CLK); @(negedge CLK);
      chk("lat_n2.valid", 32'(VALID), 32'd1);
      chk("lat_n2.key", 32'(KEY), 32'h01C);
      repeat (3) @(negedge CLK);
      KCOME = 1'b0;
      repeat (3) @(negedge CLK);
      model_byte(8'h1C, 1'b0);
      check_all("make_1c");
      do_read();
      chk("make_1c_pop", 32'(VALID), 32'd0);

      // Prefix folding
      send_byte(8'hF0); send_byte(8'h1C);
      chk("brk_1c", 32'(KEY), 32'h21C);
      do_read();
      chk("brk_1c_one", 32'(VALID), 32'd0);
      send_byte(8'hE0); send_byte(8'h75);
      chk("ext_75", 32'(KEY), 32'h175);
      do_read();
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      chk("extbrk_75", 32'(KEY), 32'h375);
      do_read();
      send_byte(8'hE0);
      chk("prefix_silent", 32'(VALID), 32'd0);
      send_byte(8'h1C);
      chk("ext_1c", 32'(KEY), 32'h11C);
      do_read();
      check_all("prefix_done");

      // Fill past capacity
      for (int i = 1; i <= 17; i++) begin
         send_byte(8'(i));
         if (i == 16) chk("full16", 32'(FULL), 32'd1);
         if (i == 16) chk("noovf16", 32'(OVF), 32'd0);
         check_all("fill");
      end
      chk("ovf17", 32'(OVF), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         chk("drain_order", 32'(KEY), 32'(i));
         do_read();
      end
      chk("drained", 32'(VALID), 32'd0);
      chk("ovf_sticky", 32'(OVF), 32'd1);
      @(negedge CLK); CLR_OVF = 1'b1;
      @(negedge CLK); CLR_OVF = 1'b0;
      m_ovf = 0;
      check_all("clr_ovf");

      // Simultaneous pop and push while full
      for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));
      chk("full_again", 32'(FULL), 32'd1);
      @(negedge CLK);
      KCODE = 8'h2A;
      KCOME = 1'b1;
      @(posedge CLK); @(posedge CLK);
      @(negedge CLK); RD = 1'b1;
      @(negedge CLK); RD = 1'b0;
      model_byte(8'h2A, 1'b1);
      chk("simul.full", 32'(FULL), 32'd1);
      chk("simul.ovf", 32'(OVF), 32'd0);
      chk("simul.head", 32'(KEY), 32'h031);
      repeat (3) @(negedge CLK);
      KCOME = 1'b0;
      repeat (3) @(negedge CLK);
      check_all("simul");
      for (int i = 0; i < 15; i++) do_read();
      chk("tail_2a", 32'(KEY), 32'h02A);
      do_read();
      do_read();
      check_all("rd_empty");
      send_byte(8'h1C);
      chk("after_empty_rd", 32'(KEY), 32'h01C);
      do_read();

      // Error bytes
      send_byte(8'h00); send_byte(8'hFF);
      send_byte(8'hF0); send_byte(8'h00);
      send_byte(8'hF0); send_byte(8'hFF);
      chk("err_dropped", 32'(VALID), 32'd0);
      send_byte(8'h1C);
      chk("err_then_1c", 32'(KEY), 32'h01C);
      do_read();

      // Reset between prefix and code, and reset released under a live strobe
      send_byte(8'hF0);
      do_reset();
      send_byte(8'h1C);
      chk("rst_mid_seq", 32'(KEY), 32'h01C);
      check_all("rst_mid_seq");
      @(negedge CLK);
      KCODE = 8'h5A;
      KCOME = 1'b1;
      do_reset();
      repeat (4) @(negedge CLK);
      KCOME = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_live_strobe", 32'(VALID), 32'd0);
      send_byte(8'h1C);
      chk("rst_live_then_1c", 32'(KEY), 32'h01C);
      do_read();

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 6) begin
            case ($urandom_range(0, 7))
               0: b = 8'hE0;
               1: b = 8'hF0;
               2: begin
                  case ($urandom_range(0, 2))
                     0: b = 8'h00;
                     1: b = 8'hFF;
                     default: b = 8'hE1;
                  endcase
               end
               default: b = 8'($urandom);
            endcase
            send_byte(b);
         end else begin
            do_read();
         end
         if ($urandom_range(0, 19) == 0) begin
            @(negedge CLK); CLR_OVF = 1'b1;
            @(negedge CLK); CLR_OVF = 1'b0;
            m_ovf = 0;
         end
         check_all("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
